// File: rtl/mem_master_arbiter.sv
// mem_master_arbiter: shares one picorv32-style memory bus between two
// masters (m0 = core, m1 = DMA/debug). One master is granted per
// transaction, round-robin on ties, and the grant is held until the slave
// answers with s_ready.
//
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog. A BUSY phase
// that lasts TIMEOUT_CYCLES cycles without s_ready is then completed
// towards the master with ERR_RDATA, and the sticky timeout_err flag is set.
// Without the macro, BUSY waits indefinitely and timeout_err is tied to 0.

module mem_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hdeadbeef
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,

  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;

  // High when the watchdog has reached its final cycle in the current BUSY.
  logic   tcnt_max;
  // Pulses in the cycle where a timed-out access is completed.
  logic   to_fire;

  // State and last-served registers; reset makes m0 win the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Grant decision, bus muxing and completion handling for the granted master.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    s_valid  = 1'b0;
    s_addr   = 32'h0;
    s_wdata  = 32'h0;
    s_wstrb  = 4'h0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
    to_fire  = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_d = last_q ? BUSY0 : BUSY1;
        end else if (m0_valid) begin
          state_d = BUSY0;
        end else if (m1_valid) begin
          state_d = BUSY1;
        end
      end

      BUSY0: begin
        s_valid  = m0_valid;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready;
        if (s_ready) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (!m0_valid) begin
          state_d = IDLE;
        end else if (tcnt_max) begin
          s_valid  = 1'b0;
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
          to_fire  = 1'b1;
          state_d  = IDLE;
          last_d   = 1'b0;
        end
      end

      BUSY1: begin
        s_valid  = m1_valid;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready;
        if (s_ready) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (!m1_valid) begin
          state_d = IDLE;
        end else if (tcnt_max) begin
          s_valid  = 1'b0;
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
          to_fire  = 1'b1;
          state_d  = IDLE;
          last_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          terr_q, terr_d;

  assign tcnt_max    = (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = terr_q;

  // Counter runs only while a BUSY phase continues; any exit or IDLE clears it.
  always_comb begin
    tcnt_d = '0;
    terr_d = terr_q | to_fire;
    if ((state_q != IDLE) && (state_d != IDLE)) begin
      tcnt_d = tcnt_q + CW'(1);
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      terr_q <= terr_d;
    end
  end
`else
  logic unused_cfg;

  assign tcnt_max    = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = to_fire ^ TIMEOUT_CYCLES[0];
`endif

endmodule

// File: tb/tb_mem_master_arbiter.sv
// tb_mem_master_arbiter: table of directed cycles (reset, tie/alternate,
// single read, isolation, abort, protocol drop), a watchdog sequence, and a
// randomized run checked against a transaction-level reference model.

module tb_mem_master_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;
  localparam logic [31:0] RD = 32'hCAFE_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0Valid, m0Ready, m1Valid, m1Ready;
  logic [31:0] m0Addr, m0Wdata, m0Rdata, m1Addr, m1Wdata, m1Rdata;
  logic [3:0]  m0Wstrb, m1Wstrb;
  logic        sValid, sReady;
  logic [31:0] sAddr, sWdata, sRdata;
  logic [3:0]  sWstrb;
  logic        timeoutErr;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_master_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERR)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (m0Valid),
    .m0_ready   (m0Ready),
    .m0_addr    (m0Addr),
    .m0_wdata   (m0Wdata),
    .m0_wstrb   (m0Wstrb),
    .m0_rdata   (m0Rdata),
    .m1_valid   (m1Valid),
    .m1_ready   (m1Ready),
    .m1_addr    (m1Addr),
    .m1_wdata   (m1Wdata),
    .m1_wstrb   (m1Wstrb),
    .m1_rdata   (m1Rdata),
    .s_valid    (sValid),
    .s_ready    (sReady),
    .s_addr     (sAddr),
    .s_wdata    (sWdata),
    .s_wstrb    (sWstrb),
    .s_rdata    (sRdata),
    .timeout_err(timeoutErr)
  );

  typedef struct {
    logic        rstn, v0, v1, sr;
    logic [31:0] rd, a0, a1, wd1;
    logic [3:0]  ws1;
    logic        sv, r0, r1;
    logic [31:0] ea, ew;
    logic [3:0]  es;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic rstn, v0, v1, sr,
                                 input logic [31:0] rd, a0, a1, wd1,
                                 input logic [3:0] ws1,
                                 input logic sv, r0, r1,
                                 input logic [31:0] ea, ew,
                                 input logic [3:0] es);
    vec_t v;
    v.rstn = rstn; v.v0 = v0; v.v1 = v1; v.sr = sr;
    v.rd = rd; v.a0 = a0; v.a1 = a1; v.wd1 = wd1; v.ws1 = ws1;
    v.sv = sv; v.r0 = r0; v.r1 = r1; v.ea = ea; v.ew = ew; v.es = es;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstn, v0, v1, sr,
                               input logic [31:0] rd, a0, a1, wd0, wd1,
                               input logic [3:0] ws0, ws1);
    resetn  = rstn;
    m0Valid = v0;
    m1Valid = v1;
    sReady  = sr;
    sRdata  = rd;
    m0Addr  = a0;
    m1Addr  = a1;
    m0Wdata = wd0;
    m1Wdata = wd1;
    m0Wstrb = ws0;
    m1Wstrb = ws1;
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, RD, A0, A1, W0, W1, 4'h0, 4'h0);
      @(negedge clk);
    end
  endtask

  // Transaction-level reference model state.
  int          owner, lastM, waited;
  bit          errM;
  bit          pend[2], prevReady[2];
  logic [31:0] pa[2], pw[2];
  logic [3:0]  ps[2];

  initial begin
    logic rst, sr, fire;
    logic [31:0] rd, eA, eW, eRd0, eRd1;
    logic [3:0]  eS;
    logic        eSv;
    bit          eR[2];

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, RD, A0, A1, W0, W1, 4'h0, 4'h3);
    @(negedge clk);
    @(negedge clk);

    // Directed cycle table.
    for (int i = 0; i < 3; i++)
      addVec(0,1,1,0, RD, A0, A1, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,1,1, RD,   A0, A1, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,1,1, RD+1, A0, A1, W1, 4'h3, 1,1,0, A0, W0, 4'h0);
    addVec(1,1,1,1, RD+2, A0, A1, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,1,1, RD+3, A0, A1, W1, 4'h3, 1,0,1, A1, W1, 4'h3);
    addVec(1,1,1,1, RD+4, A0, A1, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,1,1, RD+5, A0, A1, W1, 4'h3, 1,1,0, A0, W0, 4'h0);
    addVec(1,1,1,1, RD+6, A0, A1, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,1,1, RD+7, A0, A1, W1, 4'h3, 1,0,1, A1, W1, 4'h3);
    addVec(1,0,0,0, RD, A0, A1, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,0,0, RD, 32'h10, A1, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,0,0, RD, 32'h10, A1, W1, 4'h3, 1,0,0, 32'h10, W0, 4'h0);
    addVec(1,1,0,0, RD, 32'h10, A1, W1, 4'h3, 1,0,0, 32'h10, W0, 4'h0);
    addVec(1,1,0,1, 32'h12345678, 32'h10, A1, W1, 4'h3, 1,1,0, 32'h10, W0, 4'h0);
    addVec(1,0,0,0, RD, 32'h10, A1, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,1,0, RD, 32'h10, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'hF, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,1,0, RD, 32'h10, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'hF, 1,0,0, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'hF);
    addVec(1,1,1,1, RD, 32'h10, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'hF, 1,0,1, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'hF);
    addVec(1,1,0,0, RD, 32'h10, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'hF, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,0,1, RD, 32'h10, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'hF, 1,1,0, 32'h10, W0, 4'h0);
    addVec(1,0,1,0, RD, A0, 32'h300, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,0,1,0, RD, A0, 32'h300, W1, 4'h3, 1,0,0, 32'h300, W1, 4'h3);
    addVec(0,0,1,0, RD, A0, 32'h300, W1, 4'h3, 1,0,0, 32'h300, W1, 4'h3);
    addVec(1,1,1,0, RD, A0, 32'h300, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,1,1, RD, A0, 32'h300, W1, 4'h3, 1,1,0, A0, W0, 4'h0);
    addVec(1,0,0,0, RD, A0, 32'h300, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,0,1,0, RD, A0, 32'h400, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,0,1,0, RD, A0, 32'h400, W1, 4'h3, 1,0,0, 32'h400, W1, 4'h3);
    addVec(1,0,0,0, RD, A0, 32'h400, W1, 4'h3, 0,0,0, 32'h400, W1, 4'h3);
    addVec(1,1,1,0, RD, A0, 32'h400, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);
    addVec(1,1,1,1, RD, A0, 32'h400, W1, 4'h3, 1,0,1, 32'h400, W1, 4'h3);
    addVec(1,0,0,0, RD, A0, 32'h400, W1, 4'h3, 0,0,0, 32'h0, 32'h0, 4'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstn, vecs[i].v0, vecs[i].v1, vecs[i].sr, vecs[i].rd,
                    vecs[i].a0, vecs[i].a1, W0, vecs[i].wd1, 4'h0, vecs[i].ws1);
      #1;
      checkOutput($sformatf("vec%0d s_valid", i), sValid, vecs[i].sv);
      checkOutput($sformatf("vec%0d m0_ready", i), m0Ready, vecs[i].r0);
      checkOutput($sformatf("vec%0d m1_ready", i), m1Ready, vecs[i].r1);
      checkOutput($sformatf("vec%0d s_addr", i), sAddr, vecs[i].ea);
      checkOutput($sformatf("vec%0d s_wdata", i), sWdata, vecs[i].ew);
      checkOutput($sformatf("vec%0d s_wstrb", i), sWstrb, vecs[i].es);
      checkOutput($sformatf("vec%0d m0_rdata", i), m0Rdata, vecs[i].rd);
      checkOutput($sformatf("vec%0d m1_rdata", i), m1Rdata, vecs[i].rd);
      checkOutput($sformatf("vec%0d timeout_err", i), timeoutErr, 1'b0);
      @(negedge clk);
    end

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: forced completion on the TO-th BUSY cycle.
    resetCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, RD, 32'h20, A1, W0, W1, 4'h0, 4'h0);
    #1;
    checkOutput("to idle s_valid", sValid, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= TO; k++) begin
      #1;
      checkOutput($sformatf("to busy%0d s_valid", k), sValid, (k < TO) ? 1'b1 : 1'b0);
      checkOutput($sformatf("to busy%0d m0_ready", k), m0Ready, (k < TO) ? 1'b0 : 1'b1);
      checkOutput($sformatf("to busy%0d m0_rdata", k), m0Rdata, (k < TO) ? RD : ERR);
      checkOutput($sformatf("to busy%0d m1_rdata", k), m1Rdata, RD);
      checkOutput($sformatf("to busy%0d timeout_err", k), timeoutErr, 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, RD, 32'h20, A1, W0, W1, 4'h0, 4'h0);
      #1;
      checkOutput($sformatf("to sticky%0d timeout_err", k), timeoutErr, 1'b1);
      checkOutput($sformatf("to sticky%0d s_valid", k), sValid, 1'b0);
      @(negedge clk);
    end
    // s_ready arriving on the final watchdog cycle is a normal completion.
    resetCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, RD, 32'h24, A1, W0, W1, 4'h0, 4'h0);
    @(negedge clk);
    for (int k = 1; k < TO; k++) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 32'h24, A1, W0, W1, 4'h0, 4'h0);
    #1;
    checkOutput("race m0_ready", m0Ready, 1'b1);
    checkOutput("race s_valid", sValid, 1'b1);
    checkOutput("race m0_rdata", m0Rdata, 32'h55);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, RD, 32'h24, A1, W0, W1, 4'h0, 4'h0);
    #1;
    checkOutput("race timeout_err", timeoutErr, 1'b0);
    @(negedge clk);
`else
    // Without the watchdog, a silent slave stalls the master indefinitely.
    resetCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, RD, 32'h20, A1, W0, W1, 4'h0, 4'h0);
    @(negedge clk);
    for (int k = 1; k <= 300; k++) begin
      #1;
      checkOutput($sformatf("stall%0d s_valid", k), sValid, 1'b1);
      checkOutput($sformatf("stall%0d m0_ready", k), m0Ready, 1'b0);
      checkOutput($sformatf("stall%0d timeout_err", k), timeoutErr, 1'b0);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h77, 32'h20, A1, W0, W1, 4'h0, 4'h0);
    #1;
    checkOutput("stall end m0_ready", m0Ready, 1'b1);
    checkOutput("stall end m0_rdata", m0Rdata, 32'h77);
    @(negedge clk);
`endif

    // Randomized traffic against the reference model.
    resetCycles(2);
    owner = -1; lastM = 1; waited = 0; errM = 0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; prevReady[m] = 0;
      pa[m] = 32'h0; pw[m] = 32'h0; ps[m] = 4'h0;
    end

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      for (int m = 0; m < 2; m++) begin
        if (prevReady[m]) pend[m] = 0;
        if (pend[m] && ($urandom_range(0, 39) == 0)) begin
          pend[m] = 0;
        end else if (!pend[m] && ($urandom_range(0, 2) == 0)) begin
          pend[m] = 1;
          pa[m] = $urandom;
          pw[m] = $urandom;
          ps[m] = 4'($urandom_range(0, 15));
        end
      end
      sr = rst && ($urandom_range(0, 2) == 0);
      rd = $urandom;
      resetn  = rst;
      m0Valid = pend[0]; m1Valid = pend[1];
      sReady  = sr;      sRdata  = rd;
      m0Addr  = pa[0];   m1Addr  = pa[1];
      m0Wdata = pw[0];   m1Wdata = pw[1];
      m0Wstrb = ps[0];   m1Wstrb = ps[1];
      #1;

      eSv = 0; eA = 0; eW = 0; eS = 0; eRd0 = rd; eRd1 = rd; fire = 0;
      eR[0] = 0; eR[1] = 0;
      if (owner >= 0) begin
        eSv = pend[owner];
        eA = pa[owner]; eW = pw[owner]; eS = ps[owner];
        eR[owner] = sr;
        if (TO_EN && !sr && pend[owner] && (waited == TO - 1)) begin
          fire = 1; eSv = 0; eR[owner] = 1;
          if (owner == 0) eRd0 = ERR; else eRd1 = ERR;
        end
      end
      checkOutput($sformatf("rnd%0d s_valid", c), sValid, eSv);
      checkOutput($sformatf("rnd%0d m0_ready", c), m0Ready, eR[0]);
      checkOutput($sformatf("rnd%0d m1_ready", c), m1Ready, eR[1]);
      checkOutput($sformatf("rnd%0d s_addr", c), sAddr, eA);
      checkOutput($sformatf("rnd%0d s_wdata", c), sWdata, eW);
      checkOutput($sformatf("rnd%0d s_wstrb", c), sWstrb, eS);
      checkOutput($sformatf("rnd%0d m0_rdata", c), m0Rdata, eRd0);
      checkOutput($sformatf("rnd%0d m1_rdata", c), m1Rdata, eRd1);
      checkOutput($sformatf("rnd%0d timeout_err", c), timeoutErr, errM);

      if (!rst) begin
        owner = -1; lastM = 1; errM = 0; waited = 0;
      end else if (owner < 0) begin
        waited = 0;
        if (pend[0] && pend[1]) owner = 1 - lastM;
        else if (pend[0])       owner = 0;
        else if (pend[1])       owner = 1;
      end else if (sr || fire) begin
        lastM = owner;
        if (fire) errM = 1;
        owner = -1;
      end else if (!pend[owner]) begin
        owner = -1;
      end else begin
        waited++;
      end
      prevReady[0] = eR[0];
      prevReady[1] = eR[1];
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
